// File: rtl/decoder_onehot_pipe.sv
// Registered binary-to-one-hot decoder with valid/ready on both sides,
// a selectable out-of-range policy and a saturating out-of-range counter.
module decoder_onehot_pipe #(
  parameter int N_OUT    = 7,
  parameter int SEL_W    = 3,
  parameter int OOR_MODE = 0,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] one_hot,
  output logic             oor,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [N_OUT-1:0]   oh_q, oh_d;
  logic               oor_q, oor_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;

  assign in_ready = (state_q == EMPTY) || out_ready;
  assign accept   = in_valid && in_ready;

  // Decode of the incoming select; only loaded into the holding register on accept.
  always_comb begin
    oh_d  = '0;
    oor_d = (32'(sel) >= 32'(N_OUT));
    for (int unsigned i = 0; i < N_OUT; i++) begin
      if (sel == SEL_W'(i)) oh_d[i] = 1'b1;
    end
    if (oor_d && (OOR_MODE == 0)) oh_d[N_OUT-1] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    if (accept)         state_d = FULL;
    else if (out_ready) state_d = EMPTY;
  end

  // Clear dominates a simultaneous out-of-range accept.
  always_comb begin
    cnt_d = cnt_q;
    if (err_clr)                            cnt_d = '0;
    else if (accept && oor_d && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      oh_q    <= '0;
      oor_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        oh_q  <= oh_d;
        oor_q <= oor_d;
      end
    end
  end

  assign out_valid = (state_q == FULL);
  assign one_hot   = oh_q;
  assign oor       = oor_q;
  assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_decoder_onehot_pipe.sv
// Bench for decoder_onehot_pipe: two instances (saturate/CNT_W=8 and
// zero-output/CNT_W=2) share stimulus and are checked against a behavioural model.
module tb_decoder_onehot_pipe;

  localparam int N     = 7;
  localparam int SW    = 3;
  localparam int NDUT  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, out_ready, err_clr;
  logic [SW-1:0] sel;

  logic          in_ready  [NDUT];
  logic          out_valid [NDUT];
  logic [N-1:0]  one_hot   [NDUT];
  logic          oor       [NDUT];
  logic [7:0]    cnt0;
  logic [1:0]    cnt1;
  logic [7:0]    err_cnt   [NDUT];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  decoder_onehot_pipe #(.N_OUT(N), .SEL_W(SW), .OOR_MODE(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]), .sel(sel),
    .out_valid(out_valid[0]), .out_ready(out_ready), .one_hot(one_hot[0]), .oor(oor[0]),
    .err_clr(err_clr), .err_cnt(cnt0)
  );

  decoder_onehot_pipe #(.N_OUT(N), .SEL_W(SW), .OOR_MODE(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]), .sel(sel),
    .out_valid(out_valid[1]), .out_ready(out_ready), .one_hot(one_hot[1]), .oor(oor[1]),
    .err_clr(err_clr), .err_cnt(cnt1)
  );

  assign err_cnt[0] = cnt0;
  assign err_cnt[1] = {6'b0, cnt1};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural model: one held result per instance.
  int     m_mode   [NDUT] = '{0, 1};
  int     m_cmax   [NDUT] = '{255, 3};
  bit     m_valid  [NDUT];
  longint m_oh     [NDUT];
  bit     m_oor    [NDUT];
  int     m_cnt    [NDUT];

  function automatic longint decode(input int mode, input int s);
    if (s < N)        return longint'(1) << s;
    else if (mode==0) return longint'(1) << (N-1);
    else              return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < NDUT; k++) begin
      if (!rst_n) begin
        m_valid[k] = 0; m_oh[k] = 0; m_oor[k] = 0; m_cnt[k] = 0;
      end else begin
        bit acc;
        acc = in_valid && (!m_valid[k] || out_ready);
        if (err_clr) m_cnt[k] = 0;
        else if (acc && int'(sel) >= N && m_cnt[k] < m_cmax[k]) m_cnt[k] = m_cnt[k] + 1;
        if (acc) begin
          m_valid[k] = 1;
          m_oh[k]    = decode(m_mode[k], int'(sel));
          m_oor[k]   = (int'(sel) >= N);
        end else if (out_ready) begin
          m_valid[k] = 0;
        end
      end
    end
  end

  // Single compare process, every cycle.
  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("cyc%0d.out_valid", k), 64'(out_valid[k]), 64'(m_valid[k]));
      chk($sformatf("cyc%0d.one_hot", k),   64'(one_hot[k]),   64'(m_oh[k]));
      chk($sformatf("cyc%0d.oor", k),       64'(oor[k]),       64'(m_oor[k]));
      chk($sformatf("cyc%0d.err_cnt", k),   64'(err_cnt[k]),   64'(m_cnt[k]));
      chk($sformatf("cyc%0d.in_ready", k),  64'(in_ready[k]),  64'(!m_valid[k] || out_ready));
      chk($sformatf("cyc%0d.onehot_pop", k), 64'($countones(one_hot[k]) <= 1), 64'(1));
    end
  end

  task automatic drive(input bit v, input int s, input bit r, input bit c);
    in_valid = v; sel = SW'(s); out_ready = r; err_clr = c;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic lit(input int k, input string tag, input bit v, input int oh,
                     input bit o, input int c);
    chk({tag, ".out_valid"}, 64'(out_valid[k]), 64'(v));
    chk({tag, ".one_hot"},   64'(one_hot[k]),   64'(oh));
    chk({tag, ".oor"},       64'(oor[k]),       64'(o));
    chk({tag, ".err_cnt"},   64'(err_cnt[k]),   64'(c));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    #2;
    for (int k = 0; k < NDUT; k++) begin
      lit(k, $sformatf("rst%0d", k), 0, 0, 0, 0);
      chk($sformatf("rst%0d.in_ready", k), 64'(in_ready[k]), 64'(1));
    end
    step(); step();
    rst_n = 1'b1;
    step(); step();
    lit(0, "idle0", 0, 0, 0, 0);

    // Sweep with out_ready high: one result per cycle, one cycle latency.
    for (int s = 0; s < 8; s++) begin
      drive(1, s, 1, 0);
      step();
      if (s < 7) begin
        lit(0, $sformatf("sweep0.s%0d", s), 1, 1 << s, 0, 0);
        lit(1, $sformatf("sweep1.s%0d", s), 1, 1 << s, 0, 0);
      end else begin
        lit(0, "sweep0.s7", 1, 7'b1000000, 1, 1);
        lit(1, "sweep1.s7", 1, 7'b0000000, 1, 1);
      end
    end

    // Drain without refill keeps the last data.
    drive(0, 0, 1, 0);
    step();
    lit(0, "drain0", 0, 7'b1000000, 1, 1);

    // Backpressure.
    drive(1, 3, 1, 0);
    step();
    lit(0, "bp.accept", 1, 7'b0001000, 0, 1);
    drive(1, 5, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      lit(0, $sformatf("bp.hold%0d", i), 1, 7'b0001000, 0, 1);
      chk($sformatf("bp.in_ready%0d", i), 64'(in_ready[0]), 64'(0));
    end
    out_ready = 1'b1;
    #1;
    chk("bp.in_ready_release", 64'(in_ready[0]), 64'(1));
    step();
    lit(0, "bp.next", 1, 7'b0100000, 0, 1);

    // Counter saturation on the CNT_W=2 instance, then clear-wins.
    drive(0, 0, 1, 1);
    step();
    chk("clr.cnt0", 64'(err_cnt[0]), 64'(0));
    chk("clr.cnt1", 64'(err_cnt[1]), 64'(0));
    for (int i = 1; i <= 5; i++) begin
      drive(1, 7, 1, 0);
      step();
      chk($sformatf("sat.cnt1.%0d", i), 64'(err_cnt[1]), 64'(i < 3 ? i : 3));
      chk($sformatf("sat.cnt0.%0d", i), 64'(err_cnt[0]), 64'(i));
    end
    drive(1, 7, 1, 1);
    step();
    chk("clrwin.cnt0", 64'(err_cnt[0]), 64'(0));
    chk("clrwin.cnt1", 64'(err_cnt[1]), 64'(0));
    chk("clrwin.oor1", 64'(oor[1]), 64'(1));

    // Mid-stream reset while holding a result.
    drive(1, 2, 1, 0);
    step();
    lit(0, "mid.pre", 1, 7'b0000100, 0, 0);
    drive(0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      lit(k, $sformatf("mid.rst%0d", k), 0, 0, 0, 0);
      chk($sformatf("mid.in_ready%0d", k), 64'(in_ready[k]), 64'(1));
    end
    step();
    rst_n = 1'b1;
    drive(1, 1, 1, 0);
    step();
    lit(0, "mid.after", 1, 7'b0000010, 0, 0);

    // Randomised traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 40) == 0));
      if ($urandom_range(0, 700) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      step();
    end

    drive(0, 0, 1, 0);
    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/decoder_onehot_pipe.md
# decoder_onehot_pipe

Parametrised, registered binary-to-one-hot decoder with a valid/ready handshake on both sides. It generalises the fixed 3-to-7 select decoder in the soft processor to any output count and a selectable out-of-range policy. It also counts out-of-range selects. It sits between the instruction-decode stage and the register-file, peripheral and mux select lines, and provides one pipeline stage of isolation.

## Interface
Parameters:
- N_OUT, 7, number of one-hot outputs; legal range 2..64.
- SEL_W, 3, select width; must satisfy 2^SEL_W >= N_OUT.
- OOR_MODE, 0, out-of-range policy: 0 = saturate to the top output (bit N_OUT-1); 1 = all-zero output with the oor flag set.
- CNT_W, 8, width of the out-of-range event counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  sel is valid this cycle.
- in_ready  out  1  block can accept a select this cycle.
- sel  in  SEL_W  binary select.
- out_valid  out  1  one_hot and oor hold a decoded result.
- out_ready  in  1  consumer accepts the result this cycle.
- one_hot  out  N_OUT  registered one-hot (or all-zero) decode.
- oor  out  1  registered flag: the held result came from sel >= N_OUT.
- err_clr  in  1  synchronous clear of err_cnt.
- err_cnt  out  CNT_W  saturating count of accepted out-of-range selects.

## Operation
- Single-entry output register with no internal FIFO.
- in_ready = !out_valid || out_ready. This is combinational, with no path from in_valid.
- Accept: in_valid && in_ready. On an accept edge:
  - one_hot, oor and out_valid load.
  - out_valid becomes 1.
- Drain without refill: out_valid && out_ready && !in_valid. out_valid clears to 0. one_hot and oor keep their last value; consumers must qualify them with out_valid.
- Decode for sel < N_OUT: one_hot = 1 << sel, oor = 0.
- Decode for sel >= N_OUT (only possible when 2^SEL_W > N_OUT):
  - OOR_MODE=0: one_hot = 1 << (N_OUT-1), oor = 1.
  - OOR_MODE=1: one_hot = 0, oor = 1.
- err_cnt increments by 1 on each accepted out-of-range select and saturates at 2^CNT_W-1 (no wrap).
- err_clr sets err_cnt to 0 on the next edge. If err_clr and an out-of-range accept occur in the same cycle, clear wins and the result is 0.
- No state machine beyond the out_valid bit: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL on accept.
  - FULL -> FULL on accept with out_ready (back-to-back).
  - FULL -> EMPTY on out_ready without accept.
  - FULL holds while out_ready=0; in_ready=0 and all outputs are stable.

## Timing
- Reset values (asynchronous, immediate on rst_n low): out_valid=0, one_hot=0, oor=0, err_cnt=0. in_ready=1 follows from these.
- Latency: 1 cycle from an accept edge to out_valid=1 with the matching one_hot.
- Throughput: 1 select per cycle while out_ready is held high.
- Backpressure: while out_valid=1 and out_ready=0, one_hot, oor and out_valid stay bit-stable. in_ready=0, and sel is ignored.
- Reset asserted mid-transfer discards the held result. The first accept after rst_n rises is decoded normally.
- one_hot never has more than one bit set under any input sequence.

## Test plan
- Reset: with rst_n=0, check out_valid=0, one_hot=0, oor=0, err_cnt=0, in_ready=1. Release rst_n; outputs must hold those values until the first accept.
- Sweep, N_OUT=7, OOR_MODE=0, out_ready=1: sel=0..7, one per cycle.
  - Each result must appear 1 cycle after its accept.
  - sel 0..6 give 0000001..1000000 with oor=0.
  - sel=7 gives 1000000 with oor=1 and err_cnt=1.
- Out-of-range policy, OOR_MODE=1: sel=7 gives one_hot=0000000, oor=1, err_cnt=1.
- Backpressure:
  - Accept sel=3, then hold out_ready=0 for 5 cycles while driving sel=5 with in_valid=1.
  - one_hot must stay 0001000 and in_ready must stay 0.
  - Raise out_ready; the next accepted result is 0100000.
- Counter saturation, CNT_W=2:
  - Four out-of-range accepts give err_cnt=3, a fifth stays 3.
  - err_clr together with an out-of-range accept gives err_cnt=0.
- Mid-stream reset: assert rst_n=0 while out_valid=1 and one_hot=0000100. Outputs must go to 0 immediately; after release, sel=1 gives 0000010.
